// File: rtl/capp_pkg.sv
// Shared CAPP definitions: array geometry, resolver state encoding and derived widths.
package capp_pkg;

    localparam int unsigned CAPP_WORDS = 100;
    localparam int unsigned CAPP_BITS  = 32;
    localparam int unsigned CAPP_IDX_W = $clog2(CAPP_WORDS);
    localparam int unsigned CAPP_CNT_W = $clog2(CAPP_WORDS + 1);

    typedef enum logic [0:0] {
        RES_IDLE = 1'b0,
        RES_ITER = 1'b1
    } res_state_e;

endpackage

// File: rtl/capp_priority_encoder.sv
// Lowest-set-bit encoder: binary index plus isolated one-hot of the winning bit.
module capp_priority_encoder #(
    parameter int unsigned WORDS = 100,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic [WORDS-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [WORDS-1:0] onehot_o
);

    // Scan from the top so the lowest set bit is the last assignment to win.
    always_comb begin
        idx_o = '0;
        for (int i = int'(WORDS) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign onehot_o = vec_i & (~vec_i + WORDS'(1));

endmodule

// File: rtl/capp_response_resolver.sv
// Multiple-response resolver: latches a tag vector, counts responders and
// streams their indices lowest first, one per handshake.
module capp_response_resolver
    import capp_pkg::*;
#(
    parameter int unsigned WORDS = CAPP_WORDS,
    parameter int unsigned IDX_W = $clog2(WORDS),
    parameter int unsigned CNT_W = $clog2(WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WORDS-1:0] tag_in,
    input  logic             capture,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_index,
    output logic             resp_last,
    output logic [WORDS-1:0] sel_lines,
    output logic [CNT_W-1:0] resp_count,
    output logic             some_resp,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] ST_IDLE = 1'(RES_IDLE);
    localparam logic [0:0] ST_ITER = 1'(RES_ITER);

    logic [0:0]       state_q,   state_d;
    logic [WORDS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] remain_q,  remain_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             done_q,    done_d;
    logic [CNT_W-1:0] tag_cnt;
    logic [IDX_W-1:0] enc_idx;
    logic [WORDS-1:0] enc_onehot;

    function automatic logic [CNT_W-1:0] popcount(input logic [WORDS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    capp_priority_encoder #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_penc (
        .vec_i    (pending_q),
        .idx_o    (enc_idx),
        .onehot_o (enc_onehot)
    );

    assign tag_cnt = popcount(tag_in);

    // Capture wins over a same-cycle handshake; that handshake is simply dropped.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        remain_d  = remain_q;
        count_d   = count_q;
        done_d    = 1'b0;
        if (capture) begin
            pending_d = tag_in;
            remain_d  = tag_cnt;
            count_d   = tag_cnt;
            if (tag_cnt == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_ITER;
            end
        end else if (state_q == ST_ITER && resp_ready) begin
            pending_d = pending_q & ~enc_onehot;
            remain_d  = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            remain_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign resp_valid = (state_q == ST_ITER);
    assign resp_index = resp_valid ? enc_idx : '0;
    assign sel_lines  = resp_valid ? enc_onehot : '0;
    assign resp_last  = resp_valid && (remain_q == CNT_W'(1));
    assign resp_count = count_q;
    assign some_resp  = (count_q != '0);
    assign busy       = (state_q == ST_ITER);
    assign done       = done_q;

endmodule
